// File: rtl/operand_byte_loader_if.sv
// Operand-entry bus: raw pushbutton and switch inputs in, assembled operands out.
interface operand_byte_loader_if;
  logic        enter;
  logic [7:0]  inputdata;
  logic        loaddata;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        inputdata_ready;
  logic        operand_sel;
  logic [1:0]  byte_count;
  logic        byte_strobe;

  modport master (
    output enter, inputdata, loaddata,
    input  dataA, dataB, inputdata_ready, operand_sel, byte_count, byte_strobe
  );

  modport slave (
    input  enter, inputdata, loaddata,
    output dataA, dataB, inputdata_ready, operand_sel, byte_count, byte_strobe
  );
endinterface

// File: rtl/operand_byte_loader.sv
// Debounced pushbutton byte entry that assembles two 32-bit operands, MSB first,
// into dataA then dataB and flags completion for the multiplier datapath.
module operand_byte_loader #(
  parameter int unsigned DEBOUNCE_CYCLES   = 4,
  parameter int unsigned BYTES_PER_OPERAND = 4
) (
  input logic                 clk,
  input logic                 reset,
  operand_byte_loader_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(BYTES_PER_OPERAND - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    DONE   = 2'd2
  } state_e;

  logic             s1_q, s2_q;
  logic             stable_q, stable_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic             capture;

  state_e      state_q, state_d;
  logic [31:0] dataA_q, dataA_d;
  logic [31:0] dataB_q, dataB_d;
  logic [1:0]  byte_count_q, byte_count_d;
  logic        strobe_q, strobe_d;

  // Synchronizer and debounce run independently of the entry FSM so that
  // loaddata never disturbs a press already in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_q         <= bus.enter;
      s2_q         <= s1_q;
      stable_dly_q <= stable_q;
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= s2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign capture = stable_q & ~stable_dly_q;

  always_comb begin
    state_d      = state_q;
    dataA_d      = dataA_q;
    dataB_d      = dataB_q;
    byte_count_d = byte_count_q;
    strobe_d     = 1'b0;

    if (bus.loaddata) begin
      state_d      = LOAD_A;
      dataA_d      = '0;
      dataB_d      = '0;
      byte_count_d = '0;
    end else if (capture) begin
      case (state_q)
        LOAD_A: begin
          strobe_d = 1'b1;
          dataA_d  = {dataA_q[23:0], bus.inputdata};
          if (byte_count_q == BYTE_LAST) begin
            byte_count_d = '0;
            state_d      = LOAD_B;
          end else begin
            byte_count_d = byte_count_q + 2'd1;
          end
        end
        LOAD_B: begin
          strobe_d = 1'b1;
          dataB_d  = {dataB_q[23:0], bus.inputdata};
          if (byte_count_q == BYTE_LAST) begin
            byte_count_d = '0;
            state_d      = DONE;
          end else begin
            byte_count_d = byte_count_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD_A;
      dataA_q      <= '0;
      dataB_q      <= '0;
      byte_count_q <= '0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dataA_q      <= dataA_d;
      dataB_q      <= dataB_d;
      byte_count_q <= byte_count_d;
      strobe_q     <= strobe_d;
    end
  end

  assign bus.dataA           = dataA_q;
  assign bus.dataB           = dataB_q;
  assign bus.byte_count      = byte_count_q;
  assign bus.byte_strobe     = strobe_q;
  assign bus.operand_sel     = (state_q != LOAD_A);
  assign bus.inputdata_ready = (state_q == DONE);

endmodule

// File: tb/tb_operand_byte_loader.sv
// Directed bench for operand_byte_loader; each expected capture is queued when
// the press is driven and checked when byte_strobe appears.
module tb_operand_byte_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  operand_byte_loader_if bus ();

  operand_byte_loader #(
    .DEBOUNCE_CYCLES  (4),
    .BYTES_PER_OPERAND(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  cnt;
    logic        sel;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fails  = 0;
  int strobes  = 0;

  logic [31:0] m_a, m_b;
  logic [1:0]  m_cnt;
  int          m_state;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_a = '0; m_b = '0; m_cnt = '0; m_state = 0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    exp_t e;
    if (m_state == 0) m_a = {m_a[23:0], b};
    else              m_b = {m_b[23:0], b};
    if (m_cnt == 2'd3) begin
      m_cnt = 2'd0;
      m_state++;
    end else begin
      m_cnt = m_cnt + 2'd1;
    end
    e.a = m_a; e.b = m_b; e.cnt = m_cnt;
    e.sel = (m_state != 0);
    e.rdy = (m_state == 2);
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (bus.byte_strobe === 1'b1) begin
      strobes++;
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("cap_dataA", bus.dataA, e.a);
        check("cap_dataB", bus.dataB, e.b);
        check("cap_count", 32'(bus.byte_count), 32'(e.cnt));
        check("cap_sel", 32'(bus.operand_sel), 32'(e.sel));
        check("cap_ready", 32'(bus.inputdata_ready), 32'(e.rdy));
      end
    end
  end

  task automatic press(input logic [7:0] b, input bit expect_cap);
    @(negedge clk);
    bus.inputdata = b;
    if (expect_cap) model_push(b);
    bus.enter = 1'b1;
    repeat (8) @(negedge clk);
    bus.enter = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dataA"}, bus.dataA, 32'h0);
    check({tag, "_dataB"}, bus.dataB, 32'h0);
    check({tag, "_ready"}, 32'(bus.inputdata_ready), 32'd0);
    check({tag, "_sel"}, 32'(bus.operand_sel), 32'd0);
    check({tag, "_count"}, 32'(bus.byte_count), 32'd0);
    check({tag, "_strobe"}, 32'(bus.byte_strobe), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_loaddata();
    @(negedge clk);
    bus.loaddata = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("ld");
    @(negedge clk);
    bus.loaddata = 1'b0;
    model_clear();
  endtask

  initial begin
    int saved;
    logic [31:0] sa, sbv;
    logic [7:0] bytes_t1 [8] = '{8'h40, 8'h49, 8'h0F, 8'hDB, 8'h3F, 8'h80, 8'h00, 8'h00};

    bus.enter = 1'b0;
    bus.inputdata = 8'h00;
    bus.loaddata = 1'b0;
    model_clear();
    do_reset();
    repeat (2) @(negedge clk);

    // Bounce shorter than the debounce window
    bus.enter = 1'b1; repeat (2) @(negedge clk);
    bus.enter = 1'b0; repeat (1) @(negedge clk);
    bus.enter = 1'b1; repeat (2) @(negedge clk);
    bus.enter = 1'b0; repeat (10) @(negedge clk);
    check("bounce_count", 32'(bus.byte_count), 32'd0);
    check("bounce_dataA", bus.dataA, 32'h0);
    check("bounce_strobes", 32'(strobes), 32'd0);

    // Latency of the first byte: capture at edge k+6
    @(negedge clk);
    bus.inputdata = bytes_t1[0];
    model_push(bytes_t1[0]);
    bus.enter = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_strobe_e%0d", i), 32'(bus.byte_strobe), 32'(i == 6));
      if (i == 5) check("lat_count_before", 32'(bus.byte_count), 32'd0);
      if (i == 6) check("lat_count_after", 32'(bus.byte_count), 32'd1);
    end
    @(negedge clk);
    bus.enter = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 1; i < 8; i++) press(bytes_t1[i], 1'b1);
    check("t1_dataA", bus.dataA, 32'h40490FDB);
    check("t1_dataB", bus.dataB, 32'h3F800000);
    check("t1_ready", 32'(bus.inputdata_ready), 32'd1);
    check("t1_sel", 32'(bus.operand_sel), 32'd1);
    check("t1_strobes", 32'(strobes), 32'd8);

    // Press in DONE is ignored
    saved = strobes;
    press(8'hFF, 1'b0);
    check("done_strobes", 32'(strobes), 32'(saved));
    check("done_dataA", bus.dataA, 32'h40490FDB);
    check("done_dataB", bus.dataB, 32'h3F800000);
    check("done_ready", 32'(bus.inputdata_ready), 32'd1);

    // loaddata after two bytes of B
    do_loaddata();
    for (int i = 0; i < 6; i++) press(8'(8'h11 * (i + 1)), 1'b1);
    check("mid_b_sel", 32'(bus.operand_sel), 32'd1);
    check("mid_b_count", 32'(bus.byte_count), 32'd2);
    check("mid_b_dataB", bus.dataB, 32'h00005566);
    do_loaddata();
    press(8'h5A, 1'b1);
    check("after_ld_dataA", bus.dataA, 32'h0000005A);
    check("after_ld_count", 32'(bus.byte_count), 32'd1);

    // loaddata coinciding with a capture drops that byte
    saved = strobes;
    @(negedge clk);
    bus.inputdata = 8'hA5;
    bus.enter = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.loaddata = 1'b1;
    @(posedge clk);
    #1;
    check("ld_drop_dataA", bus.dataA, 32'h0);
    check("ld_drop_count", 32'(bus.byte_count), 32'd0);
    @(negedge clk);
    bus.loaddata = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    bus.enter = 1'b0;
    repeat (8) @(negedge clk);
    check("ld_drop_strobes", 32'(strobes), 32'(saved));

    // Reset mid-LOAD_A, then a full operand
    press(8'h01, 1'b1);
    press(8'h02, 1'b1);
    press(8'h03, 1'b1);
    check("pre_rst_count", 32'(bus.byte_count), 32'd3);
    do_reset();
    sa = 32'hC0123456;
    for (int i = 0; i < 4; i++) press(sa[31 - 8*i -: 8], 1'b1);
    sbv = bus.dataA;
    check("post_rst_dataA", sbv, 32'hC0123456);
    check("post_rst_sel", 32'(bus.operand_sel), 32'd1);
    check("post_rst_count", 32'(bus.byte_count), 32'd0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/operand_byte_loader.md
Name: operand_byte_loader

Overview:
- Upstream operand-entry stage for the floating-point multiplier datapath.
- Converts a raw pushbutton (enter) and an 8-bit switch bank (inputdata) into two 32-bit IEEE-754 operands, dataA and dataB, entered byte by byte with the most significant byte first.
- Raises inputdata_ready when both operands are complete; the multiplier unit and the display logic consume the result.
- loaddata restarts entry for a new operation.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles enter must hold a new level before it is accepted (≥2).
- BYTES_PER_OPERAND, default 4: bytes per operand; fixed at 4 for 32-bit operands, other values unsupported.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enter  input  1  raw pushbutton, active high, asynchronous to clk, may bounce.
- inputdata  input  8  byte to capture; must be stable during capture.
- loaddata  input  1  synchronous restart request, level-sampled each cycle.
- dataA  output  32  operand A assembly register.
- dataB  output  32  operand B assembly register.
- inputdata_ready  output  1  high while both operands are complete.
- operand_sel  output  1  0 = loading A, 1 = loading B or done.
- byte_count  output  2  bytes captured into the current operand.
- byte_strobe  output  1  one-cycle pulse per accepted byte.

Behaviour:
- Reset values (clock edge with reset=1): dataA=0, dataB=0, inputdata_ready=0, operand_sel=0, byte_count=0, byte_strobe=0, state LOAD_A, synchronizer and debounce registers 0.
- Reset is fully synchronous; reset mid-entry discards partial operands.
- Synchronizer: two flops s1→s2 on enter.
- Debounce, with a stable register and a counter cnt:
  - if s2==stable, cnt←0;
  - else if cnt==DEBOUNCE_CYCLES-1, stable←s2 and cnt←0;
  - else cnt←cnt+1.
- Glitches shorter than DEBOUNCE_CYCLES cycles never change stable.
- Capture event = stable & ~stable_d, a rising edge only; the release of enter causes no event.
- Latency: if k is the first edge sampling enter=1 and enter stays high, the capture occurs at edge k+DEBOUNCE_CYCLES+2 (k+6 at default). At that edge inputdata is sampled and byte_strobe goes high for exactly one cycle.
- FSM states are LOAD_A, LOAD_B and DONE.
  - LOAD_A: capture does dataA←{dataA[23:0],inputdata}, byte_count+1. The 4th capture wraps byte_count to 0 and moves to LOAD_B (operand_sel←1).
  - LOAD_B: same shift into dataB. The 4th capture wraps byte_count to 0 and moves to DONE with inputdata_ready←1, both at the same edge as the 4th shift.
  - DONE: captures are ignored, with no byte_strobe and no register change. Outputs hold until loaddata or reset.
- loaddata=1 at an edge, from any state: dataA←0, dataB←0, byte_count←0, operand_sel←0, inputdata_ready←0, state←LOAD_A.
  - The debounce state is kept.
  - A capture event in the same cycle is dropped, with no byte_strobe.
- Priority: reset > loaddata > capture.
- Holding enter high produces exactly one capture; the next capture requires a debounced release and a new press.
- Byte order: the first byte entered ends up in bits [31:24], the fourth in [7:0].

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then press enter 8 times (held 8 cycles, released 8 cycles) with inputdata 0x40,0x49,0x0F,0xDB then 0x3F,0x80,0x00,0x00. Required: dataA=0x40490FDB, dataB=0x3F800000, inputdata_ready=1 at the 8th capture edge, and exactly 8 byte_strobe pulses.
2. Single press, enter first sampled high at edge k. Required: byte_strobe high only in the cycle after edge k+6; byte_count goes 0→1 at edge k+6.
3. Bounce: enter high 2 cycles, low 1, high 2, low 10. Required: no capture, byte_count=0, dataA=0.
4. In DONE, a further press with inputdata=0xFF. Required: no byte_strobe; dataA, dataB and ready unchanged.
5. After 2 bytes into dataB, assert loaddata for 1 cycle. Required: next edge gives dataA=dataB=0, byte_count=0, operand_sel=0, ready=0; the next press loads dataA[7:0].
6. Assert reset mid-LOAD_A (byte_count=3). Required: all outputs at reset values on the next edge, and a subsequent 4-byte entry gives the correct dataA.
